// File: rtl/tpu_pkg.sv
// Shared definitions for the partial-sum accumulator.
//   PROD_W     : width of one signed PE product
//   DEF_ACC_W  : default signed accumulator width per lane
//   state_t    : accumulator FSM encoding
package tpu_pkg;
  localparam int PROD_W    = 16;
  localparam int DEF_ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/result_fifo2.sv
// Two-entry first-word-fall-through FIFO.
//   clk, reset_n : clock, async active-low reset (storage cleared too)
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry, valid while !empty
//   empty, full  : occupancy flags
module result_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  logic [1:0][DW-1:0] mem;
  logic               wp, rp;
  logic [1:0]         cnt;
  logic               do_push, do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, wp==rp: the slot being written is the head leaving this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/psum_accumulator.sv
// Per-lane saturating accumulation of systolic-array products into a
// dot-product result, queued in a 2-entry result FIFO.
//   clk, reset_n          : clock, async active-low reset
//   start, len            : begin a dot product of len beats (len==0 -> err_len)
//   in_valid/in_ready/pin : product beats, LANES x signed 16-bit
//   out_valid/out_ready   : result handshake (FWFT head)
//   out_data, out_sat     : lane sums and sticky saturation flag
//   busy                  : FSM not idle
//   err_len               : one-cycle pulse after a len==0 start in IDLE
module psum_accumulator
  import tpu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PROD_W-1:0] pin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  out_data,
  output logic                    out_sat,
  output logic                    busy,
  output logic                    err_len
);
  localparam int FW = LANES*ACC_W + 1;

  state_t                       state, state_nx;
  logic [LANES-1:0][ACC_W-1:0]  acc, acc_nx;
  logic [LANES-1:0]             lane_sat;
  logic                         sat;
  logic [CNT_W-1:0]             cnt, len_q;
  logic                         err_q;
  logic                         beat, last, push, pop;
  logic                         fifo_full, fifo_empty;
  logic [FW-1:0]                fifo_dout;

  // Returns {overflow, clamped sum}. The sum is formed one bit wider so the
  // top two bits disagree exactly when the signed add overflowed.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W:0] r;
    assign r           = sat_add(acc[i], pin[PROD_W*i +: PROD_W]);
    assign acc_nx[i]   = r[ACC_W-1:0];
    assign lane_sat[i] = r[ACC_W];
  end

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign err_len  = err_q;
  assign beat     = in_valid && in_ready;
  assign last     = beat && (cnt == len_q - 1'b1);
  assign pop      = out_valid && out_ready;
  assign push     = (state == FLUSH) && (!fifo_full || pop);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && len != '0) state_nx = ACCUM;
      ACCUM:   if (last)               state_nx = FLUSH;
      FLUSH:   if (push)               state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE) && start && (len == '0);
      if (state == IDLE && start && len != '0) begin
        len_q <= len;
        acc   <= '0;
        sat   <= 1'b0;
        cnt   <= '0;
      end else if (beat) begin
        acc <= acc_nx;
        sat <= sat | (|lane_sat);
        cnt <= cnt + 1'b1;
      end
    end
  end

  result_fifo2 #(.DW(FW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     ({sat, acc}),
    .pop     (pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[LANES*ACC_W-1:0];
  assign out_sat   = fifo_dout[FW-1];
endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, in_valid, out_ready;
  logic [7:0]   len;
  logic [63:0]  pin;
  logic         in_ready, out_valid, out_sat, busy, err_len;
  logic [127:0] out_data;
  logic         in_ready17, out_valid17, out_sat17, busy17, err_len17;
  logic [67:0]  out_data17;

  typedef struct packed {
    logic [127:0] d32;
    logic         s32;
    logic [67:0]  d17;
    logic         s17;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] fixed_q[$];
  int          n_chk = 0, n_fail = 0;
  bit          rand_rdy = 0;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .pin(pin),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy), .err_len(err_len)
  );

  psum_accumulator #(.ACC_W(17)) dut17 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready17), .pin(pin),
    .out_valid(out_valid17), .out_ready(out_ready), .out_data(out_data17),
    .out_sat(out_sat17), .busy(busy17), .err_len(err_len17)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w, inout bit s);
    longint mx, mn;
    mx = (longint'(1) <<< (w-1)) - 1;
    mn = -(longint'(1) <<< (w-1));
    if (v > mx) begin s = 1; return mx; end
    if (v < mn) begin s = 1; return mn; end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ov"}, {out_valid, out_valid17}, 0);
    chk({tag, "_od"}, out_data, 0);
    chk({tag, "_od17"}, out_data17, 0);
    chk({tag, "_sat"}, {out_sat, out_sat17}, 0);
    chk({tag, "_ir"}, {in_ready, in_ready17}, 0);
    chk({tag, "_busy"}, {busy, busy17}, 0);
    chk({tag, "_err"}, {err_len, err_len17}, 0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin tick(); g++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 300) begin tick(); g++; end
    chk("drain", exp_q.size(), 0);
  endtask

  // Drives one dot product of n accepted beats. vmode: 0 all valid,
  // 1 random valid plus stray starts, 2 alternating valid. Returns in the
  // first FLUSH cycle with the expected result queued.
  task automatic run_dot(input int n, input int vmode);
    longint      a32[4], a17[4], v;
    bit          s32 = 0, s17 = 0;
    exp_t        e;
    int          sent = 0, g = 0;
    logic [63:0] p;
    for (int i = 0; i < 4; i++) begin a32[i] = 0; a17[i] = 0; end
    start = 1; len = 8'(n);
    tick();
    start = 0;
    chk("busy_acc", busy, 1);
    while (sent < n && g < 400) begin
      chk("in_ready_acc", in_ready, 1);
      chk("err_len_acc", err_len, 0);
      case (vmode)
        0:       in_valid = 1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = (g % 2 == 0);
      endcase
      if (vmode == 1) begin
        start = 1'($urandom_range(0, 1));
        len   = 8'($urandom_range(0, 3));
      end
      if (in_valid && fixed_q.size() > 0) p = fixed_q.pop_front();
      else p = {$urandom, $urandom};
      pin = p;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          v = longint'($signed(p[16*i +: 16]));
          a32[i] = clamp(a32[i] + v, 32, s32);
          a17[i] = clamp(a17[i] + v, 17, s17);
        end
        sent++;
      end
      tick();
      g++;
    end
    if (g >= 400) chk("beat_timeout", 0, 1);
    in_valid = 0; start = 0; len = 0;
    chk("in_ready_flush", in_ready, 0);
    chk("busy_flush", busy, 1);
    chk("err_len_flush", err_len, 0);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.d32[32*i +: 32] = a32[i][31:0];
      e.d17[17*i +: 17] = a17[i][16:0];
    end
    e.s32 = s32;
    e.s17 = s17;
    exp_q.push_back(e);
  endtask

  // Scoreboard: whenever a result is visible it must be the expected head.
  initial forever begin
    @(negedge clk);
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", out_valid, 0);
      else begin
        chk("data32", out_data, exp_q[0].d32);
        chk("sat32", out_sat, exp_q[0].s32);
        chk("valid17", out_valid17, 1);
        chk("data17", out_data17, exp_q[0].d17);
        chk("sat17", out_sat17, exp_q[0].s17);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 0; start = 0; len = 0; in_valid = 0; pin = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1;

    // Small known dot product, latency to out_valid.
    fixed_q = '{64'h0001_0001_0001_0002, 64'h0001_0001_0001_FFFB, 64'h0001_0001_0001_0007};
    run_dot(3, 0);
    chk("latency_t1", out_valid, 0);
    tick();
    chk("latency_t2", out_valid, 1);
    chk("lane0", out_data[31:0], 32'd4);
    chk("lanes123", out_data[127:32], {32'd3, 32'd3, 32'd3});
    chk("sat_small", out_sat, 0);
    wait_idle();
    wait_drain();

    // len==0 start.
    start = 1; len = 0;
    tick();
    start = 0;
    chk("err_pulse", err_len, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("err_clear", err_len, 0);
    chk("err_no_result", out_valid, 0);

    // Saturation on the 17-bit accumulator.
    repeat (4) fixed_q.push_back(64'h7FFF_7FFF_7FFF_7FFF);
    out_ready = 0;
    run_dot(4, 0);
    tick();
    chk("sat17_lane0", out_data17[16:0], 17'h0FFFF);
    chk("sat17_flag", out_sat17, 1);
    chk("nosat32_lane0", out_data[31:0], 32'd131068);
    chk("nosat32_flag", out_sat, 0);
    out_ready = 1;
    wait_idle();
    wait_drain();

    // Backpressure: two queued, third held in FLUSH.
    out_ready = 0;
    run_dot(1, 0); wait_idle();
    run_dot(1, 0); wait_idle();
    run_dot(1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_busy", busy, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1;
    wait_idle();
    wait_drain();

    // Reset mid-ACCUM.
    start = 1; len = 5;
    tick();
    start = 0; in_valid = 1; pin = {$urandom, $urandom};
    tick();
    pin = {$urandom, $urandom};
    tick();
    in_valid = 0;
    #1 reset_n = 0;
    #1 chk_all_zero("mid_reset");
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1;
    run_dot(2, 0);
    wait_idle();
    wait_drain();

    // Gapped valid.
    run_dot(3, 2);
    wait_idle();
    wait_drain();

    // Random back-to-back runs with random backpressure.
    rand_rdy = 1;
    for (int r = 0; r < 25; r++) begin
      wait_idle();
      run_dot($urandom_range(1, 6), 1);
    end
    rand_rdy = 0;
    out_ready = 1;
    wait_idle();
    wait_drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
